// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
// Receive side of the VGA timing interface. Samples the asynchronous
// active-low hSync/vSync pins, rebuilds the pixel column / line counters and
// the active-area flag, measures line and frame periods, and runs a small
// SEARCH -> ACQUIRE -> LOCKED tracker that reports lock, loss of lock and
// per-event error pulses.
//
// Timing: each sync pin passes through two synchronizer flops plus one history
// flop for falling-edge detection. Every recovered output therefore trails the
// pin by exactly 3 ClkPort cycles. This lag is not compensated.
//
// All outputs are registered, or decoded directly from the state register, so
// they are clean and hold 0 throughout reset.
module vga_sync_receiver #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_BP_END    = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_BP_END    = 35,
  parameter int V_ACT_END   = 515,
  parameter int H_TOL       = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       ClkPort,
  input  logic       Reset_n,
  input  logic       hSync,
  input  logic       vSync,
  output logic [9:0] hCount_rx,
  output logic [9:0] vCount_rx,
  output logic       bright_rx,
  output logic       locked,
  output logic       lost,
  output logic       line_err,
  output logic       frame_err,
  output logic [7:0] frame_cnt,
  output logic [1:0] state_dbg
);

  // Nominal line length and the no-edge timeout, both in ClkPort cycles.
  localparam int LINE_CLKS = H_TOTAL * CLK_DIV;
  localparam int TO_CLKS   = 2 * LINE_CLKS;
  // line_clk must be able to hold the saturated timeout value itself.
  localparam int LCW       = $clog2(TO_CLKS + 1);
  localparam int CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Synchronizer and edge-history flops (idle-high after reset).
  logic h_s1, h_s2, h_s3;
  logic v_s1, v_s2, v_s3;
  logic h_fall, v_fall;

  // Tracker state.
  state_t   state, state_nx;
  logic [3:0] good_cnt, good_cnt_nx;
  logic       armed, armed_nx;
  logic       err_seen, err_seen_nx;

  // Recovered counters.
  logic [CW-1:0]  clk_cnt, clk_nx;
  logic [LCW-1:0] line_clk, line_clk_nx;
  logic [9:0]     h_nx, v_nx;

  // Check results for the current cycle.
  int         line_meas;
  int         line_dev;
  logic       bad_period;
  logic       timeout;
  logic [10:0] lines_at_v;
  logic       frame_bad;
  logic       tracking;
  logic       line_err_nx;
  logic       frame_err_nx;
  logic       any_err;
  logic       good_frame;
  logic       lost_nx;
  logic       bright_nx;
  logic [7:0] frame_cnt_nx;

  // Two-flop synchronizers plus a history flop for falling-edge detection.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      h_s1 <= 1'b1;
      h_s2 <= 1'b1;
      h_s3 <= 1'b1;
      v_s1 <= 1'b1;
      v_s2 <= 1'b1;
      v_s3 <= 1'b1;
    end else begin
      h_s1 <= hSync;
      h_s2 <= h_s1;
      h_s3 <= h_s2;
      v_s1 <= vSync;
      v_s2 <= v_s1;
      v_s3 <= v_s2;
    end
  end

  assign h_fall = h_s3 & ~h_s2;
  assign v_fall = v_s3 & ~v_s2;

  // Pixel divider, column/line counters and the line-period counter.
  // hSync restarts the column, vSync restarts the line (and wins on a tie).
  always_comb begin
    clk_nx      = clk_cnt;
    h_nx        = hCount_rx;
    v_nx        = vCount_rx;
    line_clk_nx = line_clk;
    if (h_fall) begin
      clk_nx = '0;
      h_nx   = '0;
      if (vCount_rx != 10'h3FF) v_nx = vCount_rx + 10'd1;
    end else if (clk_cnt == CW'(CLK_DIV - 1)) begin
      clk_nx = '0;
      if (hCount_rx != 10'h3FF) h_nx = hCount_rx + 10'd1;
    end else begin
      clk_nx = clk_cnt + CW'(1);
    end
    if (v_fall) v_nx = '0;
    if (h_fall) begin
      line_clk_nx = '0;
    end else if (line_clk != LCW'(TO_CLKS)) begin
      line_clk_nx = line_clk + LCW'(1);
    end
  end

  // Line/frame checks, the tracker FSM and next values of every output.
  always_comb begin
    // line_clk counts from 0 in the cycle after an edge, so the cycle
    // distance between two edges is line_clk + 1 at the second one.
    line_meas  = int'(line_clk) + 1;
    line_dev   = (line_meas > LINE_CLKS) ? (line_meas - LINE_CLKS)
                                         : (LINE_CLKS - line_meas);
    bad_period = h_fall && armed && (line_dev > H_TOL);
    timeout    = !h_fall && (line_clk == LCW'(TO_CLKS - 1));
    line_err_nx = bad_period || timeout;

    // A vSync edge that coincides with an hSync edge closes the frame with
    // that hSync edge counted as the frame's last line boundary.
    lines_at_v   = {1'b0, vCount_rx} + {10'd0, h_fall};
    frame_bad    = v_fall && (lines_at_v != 11'(V_TOTAL));
    tracking     = (state != ST_SEARCH);
    frame_err_nx = frame_bad && tracking;
    any_err      = line_err_nx || frame_err_nx;
    good_frame   = v_fall && tracking && !frame_bad && !any_err && !err_seen;

    state_nx    = state;
    good_cnt_nx = good_cnt;
    lost_nx     = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (v_fall && !line_err_nx) begin
          state_nx    = ST_ACQUIRE;
          good_cnt_nx = 4'd0;
        end
      end
      ST_ACQUIRE: begin
        if (any_err) begin
          state_nx = ST_SEARCH;
        end else if (good_frame) begin
          good_cnt_nx = good_cnt + 4'd1;
          if (good_cnt_nx == 4'(LOCK_FRAMES)) state_nx = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (any_err) begin
          state_nx = ST_SEARCH;
          lost_nx  = 1'b1;
        end
      end
      default: state_nx = ST_SEARCH;
    endcase

    frame_cnt_nx = good_frame ? (frame_cnt + 8'd1) : frame_cnt;

    // The first edge after dropping to SEARCH (or after a timeout) has no
    // trustworthy previous edge, so the next period measurement is skipped.
    armed_nx = armed;
    if (((state != ST_SEARCH) && (state_nx == ST_SEARCH)) || timeout) begin
      armed_nx = 1'b0;
    end else if (h_fall) begin
      armed_nx = 1'b1;
    end

    err_seen_nx = err_seen;
    if (v_fall) begin
      err_seen_nx = 1'b0;
    end else if (line_err_nx) begin
      err_seen_nx = 1'b1;
    end

    // Bright is decoded from the next counter values so it lines up with them.
    bright_nx = (h_nx >= 10'(H_BP_END)) && (h_nx < 10'(H_ACT_END)) &&
                (v_nx >= 10'(V_BP_END)) && (v_nx < 10'(V_ACT_END)) &&
                (state_nx != ST_SEARCH);
  end

  // State, counters and registered outputs.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_SEARCH;
      good_cnt  <= 4'd0;
      armed     <= 1'b0;
      err_seen  <= 1'b0;
      clk_cnt   <= '0;
      line_clk  <= '0;
      hCount_rx <= 10'd0;
      vCount_rx <= 10'd0;
      bright_rx <= 1'b0;
      lost      <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_nx;
      good_cnt  <= good_cnt_nx;
      armed     <= armed_nx;
      err_seen  <= err_seen_nx;
      clk_cnt   <= clk_nx;
      line_clk  <= line_clk_nx;
      hCount_rx <= h_nx;
      vCount_rx <= v_nx;
      bright_rx <= bright_nx;
      lost      <= lost_nx;
      line_err  <= line_err_nx;
      frame_err <= frame_err_nx;
      frame_cnt <= frame_cnt_nx;
    end
  end

  assign locked    = (state == ST_LOCKED);
  assign state_dbg = state;

endmodule
